pass_sequencer: RTL
===================

# pass_sequencer

Top-level run controller for the adaptive-thresholding pipeline. It takes a start request, latches the threshold offset C from the slide switches, and sequences the box-filter pass and then the threshold pass over the 256x256 image through start/done pulse handshakes. It reports progress on LEDR and measures the total cycle count of each run. A watchdog can be compiled in to abort a run when an engine hangs.

## Interface
Parameters:
- C_BITS, 5: width of threshold offset C; taken from SW[9:10-C_BITS].
- CNT_BITS, 24: width of the run cycle counter.
- TIMEOUT_BITS, 20: the watchdog limit is 2^TIMEOUT_BITS wait cycles per pass.

Ports (name, direction, width, meaning):
- clock, in, 1: single clock.
- reset, in, 1: synchronous, active-high reset.
- iStart, in, 1: run request pulse; honoured only in IDLE, DONE or ERROR.
- iSW, in, 10: slide switches.
- oC, out, C_BITS: latched threshold offset.
- oFilterStart, out, 1: one-cycle start pulse to the box filter.
- iFilterDone, in, 1: box filter finished pulse.
- oThreshStart, out, 1: one-cycle start pulse to the threshold engine.
- iThreshDone, in, 1: threshold engine finished pulse.
- oBusy, out, 1: high in any FILTER_* or THRESH_* state.
- oDone, out, 1: high in DONE.
- oError, out, 1: high in ERROR.
- oLEDR, out, 10: {oC, state one-hot}.
- oCycles, out, CNT_BITS: cycle count of the current or last run.

## Operation
- States:
  - IDLE
  - FILTER_START
  - FILTER_WAIT
  - THRESH_START
  - THRESH_WAIT
  - DONE
  - ERROR
- State transitions:
  - IDLE, DONE or ERROR with iStart=1 → FILTER_START. On the same edge: oC <= iSW[9:10-C_BITS], cycle counter <= 0.
  - FILTER_START → FILTER_WAIT, unconditionally.
  - FILTER_WAIT with iFilterDone=1 → THRESH_START.
  - THRESH_START → THRESH_WAIT, unconditionally.
  - THRESH_WAIT with iThreshDone=1 → DONE.
- All outputs are Moore outputs decoded from the registered state:
  - oFilterStart = (state == FILTER_START).
  - oThreshStart = (state == THRESH_START).
- LEDR one-hot field [4:0] by state:
  - IDLE: 00001
  - FILTER_*: 00010
  - THRESH_*: 00100
  - DONE: 01000
  - ERROR: 10000
- Done pulses are sampled only in the matching WAIT state:
  - iFilterDone outside FILTER_WAIT is ignored.
  - iThreshDone outside THRESH_WAIT is ignored.
- iStart in a busy state is ignored; it is not queued.
- Cycle counter:
  - Increments every cycle in a busy state.
  - Saturates at all-ones.
  - Holds its value in DONE, ERROR and IDLE.
  - Is driven directly to oCycles.
- Reset, including reset asserted mid-run:
  - State → IDLE; oC=0; oCycles=0; watchdog count=0.
  - oFilterStart, oThreshStart, oBusy, oDone and oError are all 0.
  - oLEDR=10'b0000000001.
  - Any engine currently running is not notified; it must be reset from the same reset.

## Timing
- iStart sampled high in IDLE at cycle t:
  - oFilterStart and the new oC are valid at cycle t+1.
  - FILTER_WAIT begins at cycle t+2.
- iFilterDone at cycle u: oThreshStart at u+1; THRESH_WAIT from u+2.
- iThreshDone at cycle v: oDone from v+1; oCycles = v - t, unless the counter saturated.
- Minimum run: done pulses arrive on the first cycle of each WAIT state. Then v = t+4 and oCycles = 4.
- Watchdog:
  - Counter clears on entry to each WAIT state and increments in each WAIT cycle without the done pulse.
  - If the count equals 2^TIMEOUT_BITS-1 and the done pulse is low, the next state is ERROR.
  - If the done pulse and the limit occur in the same cycle, done wins.

## Configuration
- PASS_SEQ_WATCHDOG_EN defined: watchdog is instantiated and ERROR is reachable.
- PASS_SEQ_WATCHDOG_EN undefined:
  - No watchdog logic; WAIT states wait indefinitely.
  - oError is tied to 0.
  - TIMEOUT_BITS is unused.

## Structure
- Shared package pass_seq_pkg:
  - State enum.
  - LED one-hot constants (LED_IDLE, LED_FILTER, LED_THRESH, LED_DONE, LED_ERROR).
  - Default widths for C_BITS and CNT_BITS.
- One sub-module, pass_watchdog:
  - Inputs: clear, count-enable.
  - Output: expired flag.
  - Parameterised by TIMEOUT_BITS.
  - Instantiated only under PASS_SEQ_WATCHDOG_EN.

## Test plan
- Reset, then idle 5 cycles → oLEDR=0x001, all pulses 0, oCycles=0.
- iSW=10'b1011000000, iStart at t; iFilterDone 10 cycles after FILTER_WAIT entry; iThreshDone 20 cycles after THRESH_WAIT entry:
  - oC=5'b10110 at t+1.
  - One oFilterStart pulse, then one oThreshStart pulse.
  - oDone high, oLEDR={10110,01000}, oCycles=32.
- iStart and spurious iThreshDone pulses during FILTER_WAIT → no state change, no extra start pulses. Then restart from DONE → new run; oCycles is cleared and recounts.
- Watchdog enabled, TIMEOUT_BITS=4, no iFilterDone:
  - ERROR entered after exactly 16 FILTER_WAIT cycles; oError=1, oLEDR[4:0]=10000.
  - A repeat with iFilterDone on the 16th wait cycle → THRESH_START, not ERROR.
- reset asserted during THRESH_WAIT → next cycle: IDLE, oC=0, oCycles=0, oLEDR=0x001.
- CNT_BITS=4, run lasting 30 cycles → oCycles saturates at 15.
- Watchdog disabled → a 100-cycle hang stays in FILTER_WAIT and oError stays 0.

Source files
------------

// File: rtl/pass_seq_pkg.sv
// rtl/pass_seq_pkg.sv - shared types and constants for the pass sequencer
package pass_seq_pkg;

    localparam int C_BITS_DEF   = 5;
    localparam int CNT_BITS_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILTER_START,
        ST_FILTER_WAIT,
        ST_THRESH_START,
        ST_THRESH_WAIT,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [4:0] LED_IDLE   = 5'b00001;
    localparam logic [4:0] LED_FILTER = 5'b00010;
    localparam logic [4:0] LED_THRESH = 5'b00100;
    localparam logic [4:0] LED_DONE   = 5'b01000;
    localparam logic [4:0] LED_ERROR  = 5'b10000;

endpackage

// File: rtl/pass_watchdog.sv
// rtl/pass_watchdog.sv - per-pass wait counter that flags an engine hang
module pass_watchdog #(
    parameter int TIMEOUT_BITS = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [TIMEOUT_BITS-1:0] count_q;
    logic [TIMEOUT_BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is evaluated on the count before this cycle's increment, so the
    // limit-th wait cycle still lets a concurrent done pulse win.
    assign expired = (count_q == {TIMEOUT_BITS{1'b1}});

endmodule

// File: rtl/pass_sequencer.sv
// rtl/pass_sequencer.sv - run controller for filter/threshold passes; watchdog under PASS_SEQ_WATCHDOG_EN
import pass_seq_pkg::*;

module pass_sequencer #(
    parameter int C_BITS       = C_BITS_DEF,
    parameter int CNT_BITS     = CNT_BITS_DEF,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iStart,
    input  logic [9:0]          iSW,
    output logic [C_BITS-1:0]   oC,
    output logic                oFilterStart,
    input  logic                iFilterDone,
    output logic                oThreshStart,
    input  logic                iThreshDone,
    output logic                oBusy,
    output logic                oDone,
    output logic                oError,
    output logic [9:0]          oLEDR,
    output logic [CNT_BITS-1:0] oCycles
);

    state_e              state_q, state_d;
    logic [C_BITS-1:0]   c_q, c_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                start_run;
    logic                wd_expired;
    logic [4:0]          led;
    logic                unused_sw;

    assign unused_sw = ^iSW;
    assign start_run = iStart && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);

`ifdef PASS_SEQ_WATCHDOG_EN
    pass_watchdog #(
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .clear    (state_q == ST_FILTER_START || state_q == ST_THRESH_START),
        .count_en ((state_q == ST_FILTER_WAIT && !iFilterDone) ||
                   (state_q == ST_THRESH_WAIT && !iThreshDone)),
        .expired  (wd_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_BITS > 0);
    assign wd_expired     = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: if (start_run) state_d = ST_FILTER_START;
            ST_FILTER_START:            state_d = ST_FILTER_WAIT;
            ST_FILTER_WAIT: begin
                if (iFilterDone)     state_d = ST_THRESH_START;
                else if (wd_expired) state_d = ST_ERROR;
            end
            ST_THRESH_START:            state_d = ST_THRESH_WAIT;
            ST_THRESH_WAIT: begin
                if (iThreshDone)     state_d = ST_DONE;
                else if (wd_expired) state_d = ST_ERROR;
            end
            default:                    state_d = ST_IDLE;
        endcase
        if (start_run) begin
            c_d   = iSW[9 -: C_BITS];
            cnt_d = '0;
        end else if (oBusy && cnt_q != {CNT_BITS{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        oFilterStart = (state_q == ST_FILTER_START);
        oThreshStart = (state_q == ST_THRESH_START);
        oBusy        = (state_q == ST_FILTER_START || state_q == ST_FILTER_WAIT ||
                        state_q == ST_THRESH_START || state_q == ST_THRESH_WAIT);
        oDone        = (state_q == ST_DONE);
`ifdef PASS_SEQ_WATCHDOG_EN
        oError       = (state_q == ST_ERROR);
`else
        oError       = 1'b0;
`endif
        case (state_q)
            ST_FILTER_START, ST_FILTER_WAIT: led = LED_FILTER;
            ST_THRESH_START, ST_THRESH_WAIT: led = LED_THRESH;
            ST_DONE:                         led = LED_DONE;
            ST_ERROR:                        led = LED_ERROR;
            default:                         led = LED_IDLE;
        endcase
    end

    assign oC      = c_q;
    assign oCycles = cnt_q;
    assign oLEDR   = {c_q, led};

endmodule
